// File: rtl/mips_defs.sv
// Shared widths and the write-request payload for the register-file writer path.
package mips_defs;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 1 << REG_AW;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Secondary write FIFO with per-entry live bits, kill-by-address and a pending-register mask.
module wb_fifo
    import mips_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  wb_req_t             push_req_i,
    input  logic                pop_i,
    input  logic                kill_i,
    input  logic [REG_AW-1:0]   kill_addr_i,
    output wb_req_t             head_o,
    output logic                head_live_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [NUM_REGS-1:0] live_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_req_t            mem_q [DEPTH];
    logic [DEPTH-1:0]   live_q,   live_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // A pushed entry racing a same-address primary write is born dead.
    always_comb begin
        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_i && (mem_q[i].addr == kill_addr_i)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop_i) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        if (push_i) begin
            live_d[wr_ptr_q] = !(kill_i && (push_req_i.addr == kill_addr_i));
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is carried by count and live bits.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign head_live_o = live_q[rd_ptr_q];
    assign empty_o     = (count_q == CNT_W'(0));
    assign full_o      = (count_q == CNT_W'(DEPTH));

    always_comb begin
        live_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                live_mask_o[mem_q[i].addr] = 1'b1;
            end
        end
        live_mask_o[0] = 1'b0;
    end

endmodule

// File: rtl/wb_write_queue.sv
// Merges pipeline writeback and buffered long-latency results onto the single
// register-file write port, with read-port bypass of the value being written.
module wb_write_queue
    import mips_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_valid,
    input  logic [REG_AW-1:0]   p_addr,
    input  logic [DATA_W-1:0]   p_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [REG_AW-1:0]   s_addr,
    input  logic [DATA_W-1:0]   s_data,
    output logic                WriteReg,
    output logic [REG_AW-1:0]   wAddr,
    output logic [DATA_W-1:0]   wData,
    input  logic [REG_AW-1:0]   rAddr1,
    input  logic [REG_AW-1:0]   rAddr2,
    input  logic [DATA_W-1:0]   rfData1,
    input  logic [DATA_W-1:0]   rfData2,
    output logic [DATA_W-1:0]   fData1,
    output logic [DATA_W-1:0]   fData2,
    output logic [NUM_REGS-1:0] pend_mask
);

    logic    armed_q;
    logic    write_reg_q, write_reg_d;
    wb_req_t wreq_q,      wreq_d;

    logic    p_take, s_push, pop;
    wb_req_t s_req, head;
    logic    head_live, empty, full;

    // armed_q blocks issue on the first edge after reset release.
    assign p_take  = armed_q && p_valid && (p_addr != REG_ZERO);
    assign s_push  = s_valid && !full && (s_addr != REG_ZERO);
    assign pop     = armed_q && !p_take && !empty;
    assign s_ready = !full;
    assign s_req   = '{addr: s_addr, data: s_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (s_push),
        .push_req_i  (s_req),
        .pop_i       (pop),
        .kill_i      (p_take),
        .kill_addr_i (p_addr),
        .head_o      (head),
        .head_live_o (head_live),
        .empty_o     (empty),
        .full_o      (full),
        .live_mask_o (pend_mask)
    );

    // Source mux: primary first, then FIFO head; a dead head burns the slot.
    always_comb begin
        write_reg_d = 1'b0;
        wreq_d      = wreq_q;
        if (p_take) begin
            write_reg_d = 1'b1;
            wreq_d      = '{addr: p_addr, data: p_data};
        end else if (pop) begin
            write_reg_d = head_live;
            if (head_live) begin
                wreq_d = head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            write_reg_q <= 1'b0;
            wreq_q      <= '0;
        end else begin
            armed_q     <= 1'b1;
            write_reg_q <= write_reg_d;
            wreq_q      <= wreq_d;
        end
    end

    assign WriteReg = write_reg_q;
    assign wAddr    = wreq_q.addr;
    assign wData    = wreq_q.data;

    assign fData1 = (write_reg_q && (wreq_q.addr == rAddr1) && (rAddr1 != REG_ZERO))
                    ? wreq_q.data : rfData1;
    assign fData2 = (write_reg_q && (wreq_q.addr == rAddr2) && (rAddr2 != REG_ZERO))
                    ? wreq_q.data : rfData2;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and randomized checks of wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_valid = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_addr = '0;
    logic [31:0] s_data = '0;
    logic        WriteReg;
    logic [4:0]  wAddr;
    logic [31:0] wData;
    logic [4:0]  rAddr1 = '0;
    logic [4:0]  rAddr2 = '0;
    logic [31:0] rfData1 = '0;
    logic [31:0] rfData2 = '0;
    logic [31:0] fData1;
    logic [31:0] fData2;
    logic [31:0] pend_mask;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (p_valid),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .WriteReg  (WriteReg),
        .wAddr     (wAddr),
        .wData     (wData),
        .rAddr1    (rAddr1),
        .rAddr2    (rAddr2),
        .rfData1   (rfData1),
        .rfData2   (rfData2),
        .fData1    (fData1),
        .fData2    (fData2),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        live;
    } ent_t;

    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic        armed = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we  = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
        armed = 1'b0;
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].live) m[mq[i].a] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] ra, input logic [31:0] rf);
        return (m_we && m_wa == ra && ra != 5'd0) ? m_wd : rf;
    endfunction

    // One clock edge of the reference: last writer wins, primary beats FIFO.
    task automatic model_edge();
        logic ptake, push, sr;
        ent_t e;
        if (!rst) return;
        sr    = (mq.size() < DEPTH);
        ptake = armed && p_valid && (p_addr != 5'd0);
        push  = s_valid && sr && (s_addr != 5'd0);
        if (ptake) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e.a == p_addr) e.live = 1'b0;
                mq[i] = e;
            end
            m_we = 1'b1; m_wa = p_addr; m_wd = p_data;
        end else if (armed && mq.size() > 0) begin
            e = mq.pop_front();
            m_we = e.live;
            if (e.live) begin m_wa = e.a; m_wd = e.d; end
        end else begin
            m_we = 1'b0;
        end
        if (push) begin
            e.a = s_addr; e.d = s_data; e.live = !(ptake && p_addr == s_addr);
            mq.push_back(e);
        end
        armed = 1'b1;
    endtask

    task automatic check_all();
        chk("WriteReg", 32'(WriteReg), 32'(m_we));
        if (m_we) begin
            chk("wAddr", 32'(wAddr), 32'(m_wa));
            chk("wData", wData, m_wd);
        end
        chk("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
        chk("pend_mask", pend_mask, model_pend());
        chk("fData1", fData1, model_fwd(rAddr1, rfData1));
        chk("fData2", fData2, model_fwd(rAddr2, rfData2));
    endtask

    task automatic step(input logic rn, input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        @(negedge clk);
        rst = rn; p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        if (!rn) model_reset();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rAddr1 = 5'd1; rAddr2 = 5'd2; rfData1 = 32'h1111_1111; rfData2 = 32'h2222_2222;

        // Reset held with traffic present
        step(1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd3, 32'h33);
        chk("rst_WriteReg", 32'(WriteReg), 32'd0);
        chk("rst_wAddr", 32'(wAddr), 32'd0);
        chk("rst_wData", wData, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        step(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
        chk("rel_edge1_WriteReg", 32'(WriteReg), 32'd0);
        step(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
        chk("rel_edge2_WriteReg", 32'(WriteReg), 32'd1);
        chk("rel_edge2_wAddr", 32'(wAddr), 32'd5);
        idle(); idle();

        // Fill behind unrelated primary traffic, then drain
        step(1'b1, 1'b1, 5'd20, 32'h20, 1'b1, 5'd1, 32'h11);
        step(1'b1, 1'b1, 5'd21, 32'h21, 1'b1, 5'd2, 32'h22);
        step(1'b1, 1'b1, 5'd22, 32'h22, 1'b1, 5'd3, 32'h33);
        chk("fill3_s_ready", 32'(s_ready), 32'd1);
        step(1'b1, 1'b1, 5'd23, 32'h23, 1'b1, 5'd4, 32'h44);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_pend", pend_mask, 32'h1E);
        idle();
        chk("drain1_wAddr", 32'(wAddr), 32'd1);
        chk("drain1_wData", wData, 32'h11);
        chk("drain1_pend", pend_mask, 32'h1C);
        idle();
        chk("drain2_wAddr", 32'(wAddr), 32'd2);
        idle();
        chk("drain3_wAddr", 32'(wAddr), 32'd3);
        idle();
        chk("drain4_wAddr", 32'(wAddr), 32'd4);
        chk("drain4_wData", wData, 32'h44);
        chk("drain4_pend", pend_mask, 32'h0);
        idle();

        // Primary priority over a queued entry
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAA);
        step(1'b1, 1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 32'h0);
        chk("prio_r6", 32'(wAddr), 32'd6);
        step(1'b1, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 32'h0);
        step(1'b1, 1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'h0);
        chk("prio_r8", 32'(wAddr), 32'd8);
        chk("prio_pend5", pend_mask, 32'h20);
        idle();
        chk("prio_r5_we", 32'(WriteReg), 32'd1);
        chk("prio_r5_data", wData, 32'hAA);

        // Kill: later primary write supersedes queued secondary
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1);
        chk("kill_pend_set", pend_mask, 32'h200);
        step(1'b1, 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
        chk("kill_pend_clr", pend_mask, 32'h0);
        chk("kill_wData", wData, 32'h2);
        idle();
        chk("kill_dead_pop", 32'(WriteReg), 32'd0);
        step(1'b1, 1'b1, 5'd10, 32'h5, 1'b1, 5'd10, 32'h6);
        chk("same_cycle_pend", pend_mask, 32'h0);
        idle();
        chk("same_cycle_dead", 32'(WriteReg), 32'd0);

        // Register 0 push and bypass
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF);
        chk("r0_s_ready", 32'(s_ready), 32'd1);
        idle();
        chk("r0_no_write", 32'(WriteReg), 32'd0);
        rAddr1 = 5'd3; rAddr2 = 5'd0; rfData1 = 32'h1111; rfData2 = 32'h2222;
        step(1'b1, 1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        chk("byp_fData1", fData1, 32'hDEAD);
        chk("byp_fData2", fData2, 32'h2222);

        // Randomized traffic with occasional mid-operation reset
        for (int n = 0; n < 600; n++) begin
            logic rn;
            rAddr1  = 5'($urandom_range(0, 7));
            rAddr2  = 5'($urandom_range(0, 7));
            rfData1 = $urandom;
            rfData2 = $urandom;
            rn = (!rst) ? 1'b1 : ($urandom_range(0, 63) != 0);
            step(rn, ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
